bit_mem_bridge: RTL

BIT_MEM_BRIDGE -- requirements
Module: bit_mem_bridge

---
 rtl/bit_mem_pkg.sv | 17 +
 rtl/bit_mem_bridge_if.sv | 44 ++++
 rtl/bit_mem_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bit_mem_pkg.sv
// Shared definitions for the bit-serial memory bridge and its memory-side benches.
//   NBITS   : memory bits moved per byte transfer (one address per bit)
//   ADDR_W  : memory address width
//   state_t : bridge FSM states
package bit_mem_pkg;

  localparam int unsigned NBITS  = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/bit_mem_bridge_if.sv
// Signal bundle for bit_mem_bridge: upstream byte write / read-back handshakes
// plus the 1-bit-wide memory write and read methods.
//   master : the bridge's view (accepts upstream requests, drives the memory)
//   slave  : the environment's view (upstream requester plus memory)
interface bit_mem_bridge_if;
  import bit_mem_pkg::*;

  // upstream write
  logic              wr_byte_valid;
  logic [NBITS-1:0]  wr_byte;
  logic              wr_byte_ready;
  // upstream read-back
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [NBITS-1:0]  rd_byte;
  logic              rd_byte_valid;
  // memory write method
  logic [ADDR_W-1:0] mem_write_address;
  logic              mem_write_data;
  logic              mem_write_en;
  logic              mem_write_rdy;
  // memory read method (data valid in the firing cycle)
  logic [ADDR_W-1:0] mem_read_address;
  logic              mem_read_en;
  logic              mem_read_data;
  logic              mem_read_rdy;

  modport master (
    input  wr_byte_valid, wr_byte, rd_req_valid,
    input  mem_write_rdy, mem_read_data, mem_read_rdy,
    output wr_byte_ready, rd_req_ready, rd_byte, rd_byte_valid,
    output mem_write_address, mem_write_data, mem_write_en,
    output mem_read_address, mem_read_en
  );

  modport slave (
    output wr_byte_valid, wr_byte, rd_req_valid,
    output mem_write_rdy, mem_read_data, mem_read_rdy,
    input  wr_byte_ready, rd_req_ready, rd_byte, rd_byte_valid,
    input  mem_write_address, mem_write_data, mem_write_en,
    input  mem_read_address, mem_read_en
  );

endinterface

// File: rtl/bit_mem_bridge.sv
// Bridges byte-wide upstream requests onto a 1-bit-wide memory.
// A write scatters wr_byte bit i to address i; a read gathers address i into
// rd_byte bit i and presents it with a one-cycle rd_byte_valid pulse.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset; all outputs are forced to 0 while high
//   bus  : bit_mem_bridge_if.master (upstream handshakes + memory methods)
//   busy : high whenever the FSM is not IDLE
module bit_mem_bridge #(
  parameter int unsigned NBITS  = bit_mem_pkg::NBITS,
  parameter int unsigned ADDR_W = bit_mem_pkg::ADDR_W
) (
  input  logic             CLK,
  input  logic             RST,
  bit_mem_bridge_if.master bus,
  output logic             busy
);
  import bit_mem_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0]  byte_q;
  logic [NBITS-1:0]  gather_q, gather_next;
  logic [NBITS-1:0]  rd_byte_q;
  logic              wr_fire, rd_fire, last_bit;

  assign wr_fire  = (state_q == WR) && bus.mem_write_rdy;
  assign rd_fire  = (state_q == RD) && bus.mem_read_rdy;
  assign last_bit = (idx_q == ADDR_W'(NBITS - 1));

  // Final gathered bit is merged here so rd_byte is already updated in RESP.
  always_comb begin
    gather_next        = gather_q;
    gather_next[idx_q] = bus.mem_read_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      byte_q    <= '0;
      gather_q  <= '0;
      rd_byte_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if ((state_q == IDLE) && bus.wr_byte_valid) begin
        byte_q <= bus.wr_byte;
      end
      if (rd_fire) begin
        gather_q <= gather_next;
        if (last_bit) begin
          rd_byte_q <= gather_next;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_byte_valid) begin
          state_d = WR;
          idx_d   = '0;
        end else if (bus.rd_req_valid) begin
          state_d = RD;
          idx_d   = '0;
        end
      end
      WR: begin
        if (wr_fire) begin
          idx_d = idx_q + ADDR_W'(1);
          if (last_bit) state_d = IDLE;
        end
      end
      RD: begin
        if (rd_fire) begin
          idx_d = idx_q + ADDR_W'(1);
          if (last_bit) state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // All outputs are gated by RST so they read 0 even before the reset edge.
  always_comb begin
    busy                  = 1'b0;
    bus.wr_byte_ready     = 1'b0;
    bus.rd_req_ready      = 1'b0;
    bus.rd_byte           = '0;
    bus.rd_byte_valid     = 1'b0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = 1'b0;
    bus.mem_write_en      = 1'b0;
    bus.mem_read_address  = '0;
    bus.mem_read_en       = 1'b0;
    if (!RST) begin
      busy        = (state_q != IDLE);
      bus.rd_byte = rd_byte_q;
      unique case (state_q)
        IDLE: begin
          bus.wr_byte_ready = 1'b1;
          bus.rd_req_ready  = !bus.wr_byte_valid;
        end
        WR: begin
          bus.mem_write_en      = bus.mem_write_rdy;
          bus.mem_write_address = idx_q;
          bus.mem_write_data    = byte_q[idx_q];
        end
        RD: begin
          bus.mem_read_en      = bus.mem_read_rdy;
          bus.mem_read_address = idx_q;
        end
        RESP: bus.rd_byte_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
